// File: rtl/four_bit_full_adder_pkg.sv
// four_bit_full_adder_pkg: shared width constant and reference add model
//   WIDTH_DEFAULT : default operand/sum width
//   ref_add       : returns {overflow, c_out, sum} for a + b + c_in
package four_bit_full_adder_pkg;
    localparam int WIDTH_DEFAULT = 4;

    function automatic logic [WIDTH_DEFAULT+1:0] ref_add(
        input logic [WIDTH_DEFAULT-1:0] a,
        input logic [WIDTH_DEFAULT-1:0] b,
        input logic                     c_in
    );
        logic [WIDTH_DEFAULT:0] t;
        logic                   ovf;
        t   = {1'b0, a} + {1'b0, b} + {{WIDTH_DEFAULT{1'b0}}, c_in};
        // Signed overflow: operands share a sign that the result does not
        ovf = (a[WIDTH_DEFAULT-1] == b[WIDTH_DEFAULT-1]) && (t[WIDTH_DEFAULT-1] != a[WIDTH_DEFAULT-1]);
        return {ovf, t};
    endfunction
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: 1-bit full-adder cell
//   a, b, cin : operand bits and carry-in
//   s, cout   : sum bit and carry-out
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/four_bit_full_adder.sv
// four_bit_full_adder: registered ripple-carry adder with valid and signed overflow
//   clk, rst        : clock, synchronous active-high reset
//   a, b, c_in      : operands and carry-in, qualified by in_valid
//   sum, c_out      : registered (a + b + c_in) and carry out of the MSB
//   overflow        : registered carry-into-MSB XOR carry-out-of-MSB
//   out_valid       : one-cycle pulse per new result
module four_bit_full_adder
    import four_bit_full_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Result registers hold their value while in_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= s;
                c_out    <= c[WIDTH];
                overflow <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_four_bit_full_adder.sv
// tb_four_bit_full_adder: directed self-checking bench for four_bit_full_adder
module tb_four_bit_full_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       c_in = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] sum;
    logic       c_out;
    logic       overflow;
    logic       out_valid;
    int         checks = 0;
    int         failures = 0;
    logic [6:0] got;

    four_bit_full_adder dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .in_valid (in_valid),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign got = {out_valid, overflow, c_out, sum};

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int t;
        logic [3:0] s;
        logic ov;
        t  = int'(x) + int'(y) + int'(ci);
        s  = t[3:0];
        ov = (x[3] == y[3]) && (s[3] != x[3]);
        return {1'b1, ov, t >= 16, s};
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; a = 4'd5; b = 4'd3; c_in = 1'b0;
        cyc; cyc;
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset got=%b want=%b", got, 7'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        a = 4'd3; b = 4'd4; c_in = 1'b0; in_valid = 1'b1;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
            failures++;
            $display("FAIL basic_3p4 got=%b want=%b", got, {1'b1, 1'b0, 1'b0, 4'd7});
        end
    endtask

    task automatic test_carry;
        a = 4'd15; b = 4'd15; c_in = 1'b1;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 4'd15}) begin
            failures++;
            $display("FAIL wrap_15p15p1 got=%b want=%b", got, {1'b1, 1'b0, 1'b1, 4'd15});
        end
        a = 4'd8; b = 4'd8; c_in = 1'b0;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL wrap_8p8 got=%b want=%b", got, {1'b1, 1'b1, 1'b1, 4'd0});
        end
        a = 4'd15; b = 4'd0; c_in = 1'b1;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL wrap_15p0p1 got=%b want=%b", got, {1'b1, 1'b0, 1'b1, 4'd0});
        end
    endtask

    task automatic test_overflow;
        a = 4'd7; b = 4'd1; c_in = 1'b0;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b1, 1'b0, 4'd8}) begin
            failures++;
            $display("FAIL ovf_7p1 got=%b want=%b", got, {1'b1, 1'b1, 1'b0, 4'd8});
        end
        a = 4'd8; b = 4'd15; c_in = 1'b0;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b1, 1'b1, 4'd7}) begin
            failures++;
            $display("FAIL ovf_neg8pneg1 got=%b want=%b", got, {1'b1, 1'b1, 1'b1, 4'd7});
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] v;
        for (int ci = 0; ci < 2; ci++) begin
            for (int k = 0; k < 256; k++) begin
                v = 8'(k);
                a = v[3:0]; b = v[7:4]; c_in = ci[0]; in_valid = 1'b1;
                cyc;
                checks++;
                if (got !== model(a, b, c_in)) begin
                    failures++;
                    $display("FAIL sweep a=%0d b=%0d ci=%0d got=%b want=%b", a, b, c_in, got, model(a, b, c_in));
                end
            end
        end
    endtask

    task automatic test_hold;
        a = 4'd9; b = 4'd5; c_in = 1'b0; in_valid = 1'b1;
        cyc;
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 4'd14}) begin
            failures++;
            $display("FAIL hold_load got=%b want=%b", got, {1'b1, 1'b0, 1'b0, 4'd14});
        end
        in_valid = 1'b0; a = 4'd1; b = 4'd1; c_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc;
            checks++;
            if (got !== {1'b0, 1'b0, 1'b0, 4'd14}) begin
                failures++;
                $display("FAIL hold_%0d got=%b want=%b", k, got, {1'b0, 1'b0, 1'b0, 4'd14});
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        in_valid = 1'b1; c_in = 1'b1;
        for (int k = 100; k < 104; k++) begin
            v = 8'(k);
            a = v[3:0]; b = v[7:4];
            cyc;
            checks++;
            if (got !== model(a, b, c_in)) begin
                failures++;
                $display("FAIL pre_rst a=%0d b=%0d got=%b want=%b", a, b, got, model(a, b, c_in));
            end
        end
        rst = 1'b1; a = 4'd12; b = 4'd7;
        cyc;
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL mid_rst got=%b want=%b", got, 7'b0);
        end
        rst = 1'b0;
        for (int k = 104; k < 108; k++) begin
            v = 8'(k);
            a = v[3:0]; b = v[7:4];
            cyc;
            checks++;
            if (got !== model(a, b, c_in)) begin
                failures++;
                $display("FAIL post_rst a=%0d b=%0d got=%b want=%b", a, b, got, model(a, b, c_in));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_overflow;
        test_exhaustive;
        test_hold;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/four_bit_full_adder.md
Name: four_bit_full_adder

Overview:
- Registered 4-bit ripple-carry adder: sum/c_out = a + b + c_in, captured on the clock edge.
- Built from a chain of 1-bit full-adder cells.
- Used as a leaf arithmetic block wherever a small registered add with carry-in/carry-out is needed.
- Adds a valid qualifier and a signed-overflow flag for downstream consumers.

Parameters:
- WIDTH, 4, operand/sum width in bits. Only 4 is verified; the RTL stays generic via a generate loop.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, unsigned (two's complement for the overflow flag).
- b  input  WIDTH  operand B, same encoding as a.
- c_in  input  1  carry-in.
- in_valid  input  1  qualifies a, b and c_in this cycle.
- sum  output  WIDTH  registered (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for one cycle when sum, c_out and overflow hold a new result.

Behaviour:
- Combinational path: ripple chain of WIDTH full-adder cells.
  - Cell i: s = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = c_in.
  - c_out = c[WIDTH]; overflow = c[WIDTH]^c[WIDTH-1].
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1.
- in_valid=0 at an edge: sum, c_out and overflow hold their previous values; out_valid=0.
- No backpressure: a new operand set is accepted every cycle (full throughput). Back-to-back valids produce back-to-back results.
- Reset: rst=1 at an edge forces sum=0, c_out=0, overflow=0, out_valid=0, overriding in_valid.
  - A transaction presented in the same cycle as reset is discarded.
  - The first edge with rst=0 and in_valid=1 produces a normal result.
- Wrap-around: 15 + 15 + 1 gives sum=15, c_out=1. 15 + 0 + 1 gives sum=0, c_out=1.
- Full width: all 512 combinations of (a, b, c_in) must be correct; no X propagation when the inputs are known.
- Before the first reset, output values are don't-care. The bench asserts reset first.

Decomposition:
- Shared package: the WIDTH default constant and a helper function computing the reference {c_out, sum} and overflow for scoreboards.
- One sub-module, full_adder_bit (a, b, cin -> s, cout), instantiated WIDTH times by a generate loop.
- Output registers and valid logic live in four_bit_full_adder.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=5, b=3 -> sum=0, c_out=0, overflow=0, out_valid=0.
- Basic add: a=3, b=4, c_in=0, in_valid=1 -> next cycle sum=7, c_out=0, overflow=0, out_valid=1.
- Carry/wrap: a=15, b=15, c_in=1 -> sum=15, c_out=1, overflow=0. Then a=8, b=8, c_in=0 -> sum=0, c_out=1, overflow=1.
- Signed overflow: a=7, b=1, c_in=0 -> sum=8, c_out=0, overflow=1.
- Exhaustive: for c_in in {0,1}, sweep {b,a} = 0..255 with in_valid=1 every cycle -> each result matches the reference one cycle later, and out_valid stays high continuously.
- Hold/reset mid-stream: drop in_valid for 3 cycles -> outputs hold, out_valid=0. Then assert rst for 1 cycle mid-sweep -> outputs zero, and the sweep resumes correctly on the next valid.
